// File: rtl/rr_sel_pkg.sv
// Shared widths and types for the 4-channel round-robin selector.
package rr_sel_pkg;

    localparam int unsigned NCH    = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned DATA_W = 4;

    typedef logic [SEL_W-1:0]  ch_idx_t;
    typedef logic [DATA_W-1:0] nib_t;

endpackage

// File: rtl/mux_4_1.sv
// Plain 4:1 nibble mux used as the data-steering element.
module mux_4_1
    import rr_sel_pkg::*;
(
    input  nib_t    d0_i,
    input  nib_t    d1_i,
    input  nib_t    d2_i,
    input  nib_t    d3_i,
    input  ch_idx_t sel_i,
    output nib_t    y_o
);

    // Decode select onto the output.
    always_comb begin
        unique case (sel_i)
            2'd0:    y_o = d0_i;
            2'd1:    y_o = d1_i;
            2'd2:    y_o = d2_i;
            default: y_o = d3_i;
        endcase
    end

endmodule

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick: first requesting channel at or after ptr.
module rr_pick_4
    import rr_sel_pkg::*;
(
    input  logic [NCH-1:0] in_valid_i,
    input  ch_idx_t        ptr_i,
    output ch_idx_t        gnt_idx_o,
    output logic           any_req_o
);

    ch_idx_t cand;

    // Walk from the farthest offset to the nearest so the channel closest to ptr wins.
    always_comb begin
        gnt_idx_o = ptr_i;
        cand      = ptr_i;
        for (int k = NCH - 1; k >= 0; k--) begin
            cand = ptr_i + ch_idx_t'(k);
            if (in_valid_i[cand]) begin
                gnt_idx_o = cand;
            end
        end
    end

    assign any_req_o = |in_valid_i;

endmodule

// File: rtl/rr_sel_4ch.sv
// Round-robin front end: arbitrates four valid/ready producers into a
// one-entry registered output and drives the shared 4:1 mux select.
module rr_sel_4ch
    import rr_sel_pkg::*;
#(
    parameter int unsigned RESET_PTR = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] in_valid,
    input  nib_t           in_data0,
    input  nib_t           in_data1,
    input  nib_t           in_data2,
    input  nib_t           in_data3,
    output logic [NCH-1:0] in_ready,
    output logic           out_valid,
    output nib_t           out_data,
    output ch_idx_t        out_sel,
    input  logic           out_ready
);

    localparam ch_idx_t PtrRst = ch_idx_t'(RESET_PTR % NCH);

    ch_idx_t ptr_q, ptr_d;
    logic    valid_q, valid_d;
    nib_t    data_q, data_d;
    ch_idx_t sel_q, sel_d;

    ch_idx_t        gnt_idx;
    logic           any_req;
    nib_t           mux_y;
    logic           load;
    logic [NCH-1:0] gnt_oh;

    rr_pick_4 u_pick (
        .in_valid_i (in_valid),
        .ptr_i      (ptr_q),
        .gnt_idx_o  (gnt_idx),
        .any_req_o  (any_req)
    );

    mux_4_1 u_mux (
        .d0_i  (in_data0),
        .d1_i  (in_data1),
        .d2_i  (in_data2),
        .d3_i  (in_data3),
        .sel_i (gnt_idx),
        .y_o   (mux_y)
    );

    // Slot is free, or being drained this cycle.
    assign load = ~valid_q | out_ready;

    // One-hot view of the winning channel.
    always_comb begin
        gnt_oh          = '0;
        gnt_oh[gnt_idx] = 1'b1;
    end

    // rst gating keeps in_ready low for the whole reset window, not just after the edge.
    assign in_ready = (load && any_req && !rst) ? gnt_oh : '0;

    // Next state: load a new word, go empty when idle, or hold while stalled.
    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        if (load) begin
            if (any_req) begin
                data_d  = mux_y;
                sel_d   = gnt_idx;
                valid_d = 1'b1;
                ptr_d   = gnt_idx + ch_idx_t'(1);
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // Pointer and output register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= PtrRst;
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: doc/rr_sel_4ch.md
Name: rr_sel_4ch

Overview:
- Sequential front end that generates the 2-bit select and 4-bit data for the existing 4:1 mux datapath.
- Four producer channels present data with valid/ready handshakes. A round-robin arbiter picks one requesting channel per transfer and drives the mux select with its index.
- The chosen nibble is captured into a one-entry output register with its own valid/ready handshake to the consumer.
- Sits directly upstream of the 4:1 mux and reuses it as the data-steering element.

Parameters:
- RESET_PTR, 0, channel index (0..3) holding highest priority after reset.

Ports:
- clk    input   1   system clock, rising edge
- rst    input   1   asynchronous active-high reset
- in_valid   input   4   per-channel request; bit i = channel i
- in_data0   input   4   channel 0 data
- in_data1   input   4   channel 1 data
- in_data2   input   4   channel 2 data
- in_data3   input   4   channel 3 data
- in_ready   output  4   per-channel accept, one-hot or zero
- out_valid  output  1   output register holds a word
- out_data   output  4   registered selected data
- out_sel    output  2   registered index of the channel that supplied out_data
- out_ready  input   1   consumer accepts out_data this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, on rst.
- Reset values: out_valid=0, out_data=0, out_sel=0, internal priority pointer ptr=RESET_PTR. in_ready is combinational; it is 0 while rst=1.
- load = ~out_valid | out_ready. The output slot is free, or is being drained this cycle.
- Grant search (combinational): scan channels ptr, ptr+1, ptr+2, ptr+3, all mod 4. The first i with in_valid[i]=1 is gnt_idx, and any_req=|in_valid.
- in_ready[i] = load & any_req & (gnt_idx==i). At most one bit is set per cycle.
- Transfer on channel i occurs when in_valid[i] & in_ready[i].
- On transfer:
  - out_data <= mux_4_1(in_data0..3, sel=gnt_idx)
  - out_sel <= gnt_idx
  - out_valid <= 1
  - ptr <= gnt_idx+1, 2-bit wrap, so 3 -> 0
- If load & ~any_req: out_valid <= 0, ptr unchanged. out_data and out_sel hold their last values.
- If out_valid & ~out_ready: all output registers and ptr hold, and in_ready=0. Output must stay stable while stalled.
- Simultaneous drain and refill (out_valid=1, out_ready=1, any_req=1): new word loaded in the same cycle. Full throughput is one word per cycle.
- Latency: input accepted in cycle N appears on out_data/out_valid in cycle N+1.
- Fairness: with all four channels continuously requesting, grants follow strict rotation. No channel waits more than 3 transfers.
- Producer rule: the producer holds in_data stable while in_valid=1 and not yet accepted. The block does not check this.
- Reset mid-operation: any word in the output register is discarded, ptr returns to RESET_PTR, and no in_ready is asserted during reset.
- Datapath width is fixed at 4 bits to match the mux.

Decomposition:
- Shared package rr_sel_pkg:
  - NCH=4, SEL_W=2, DATA_W=4
  - typedef logic [SEL_W-1:0] ch_idx_t
  - typedef logic [DATA_W-1:0] nib_t
- Sub-module rr_pick_4: combinational. Inputs in_valid[3:0] and ptr. Outputs gnt_idx and any_req.
- Data steering uses the existing mux_4_1, instantiated once, with sel=gnt_idx.
- The top level holds only the ptr and output registers plus handshake logic.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1. Required: out_valid=0, out_sel=0 and in_ready=0 immediately, asynchronously. After release with only in_valid=4'b0100 and in_data2=4'hA, in_ready=4'b0100 and the next cycle shows out_data=A, out_sel=2.
- Full contention: in_valid=4'b1111, data 1,2,3,4, out_ready=1 constantly. Required: out_sel sequence 0,1,2,3,0,... and out_data 1,2,3,4,1..., one word per cycle.
- Backpressure: fill the output with ch1 data 5, then hold out_ready=0 for 3 cycles with in_valid=4'b1111. Required: in_ready=0, and out_data=5, out_sel=1 stable. On out_ready=1, the next grant is channel 2.
- Pointer wrap and skip: ptr=3 with in_valid=4'b0011. Required: grant ch0, then ch1, then ch0. Idle channels 2 and 3 are never granted.
- Idle drain: a single word is loaded, then in_valid=0 and out_ready=1. Required: out_valid falls the next cycle and ptr is unchanged, so the next lone request from any channel is granted immediately.
- RESET_PTR=2 variant: after reset with in_valid=4'b1111, the first out_sel must be 2, then 3, 0, 1.
